// File: rtl/sd_dat_pkg.sv
// sd_dat_pkg: shared state encoding and line constants for the SD DAT0 write path.
package sd_dat_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_STOP} state_t;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam int CRC_LEN = 16;
    localparam logic [CRC_LEN-1:0] CRC_POLY = 16'h1021;
    localparam int BLOCK_BYTES_DEF = 512;
endpackage

// File: rtl/crc16.sv
// crc16: bit-serial CRC-16-CCITT with zero init; unload shifts the remainder out MSB-first on ocrc.
module crc16
    import sd_dat_pkg::*;
(
    input  logic iclk,
    input  logic irst,
    input  logic idata,
    input  logic iunload,
    output logic ocrc
);
    logic [CRC_LEN-1:0] crc_q, crc_d;
    logic fb;
    always_comb begin
        fb = iunload ? 1'b0 : idata ^ crc_q[CRC_LEN-1];
        crc_d = {crc_q[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    always_ff @(posedge iclk) begin
        if (irst) crc_q <= '0;
        else crc_q <= crc_d;
    end
    assign ocrc = crc_q[CRC_LEN-1];
endmodule

// File: rtl/sd_dat_tx_ctrl.sv
// sd_dat_tx_ctrl: sends one SD write block on DAT0: start bit, data bytes MSB-first, CRC16, end bit.
module sd_dat_tx_ctrl
    import sd_dat_pkg::*;
#(
    parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
    parameter int CNT_W = 10
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       istart,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       oready,
    output logic       odat,
    output logic       odat_oe,
    output logic       obusy,
    output logic       odone,
    output logic       oerr
);
    localparam int CRC_CNT_W = $clog2(CRC_LEN);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);
    state_t state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [CRC_CNT_W-1:0] crc_cnt_q, crc_cnt_d;
    logic done_q, done_d, err_q, err_d;
    logic crc_bit, crc_rst, last_bit, more;
    always_comb begin
        last_bit = bit_cnt_q == 3'd0;
        more = byte_cnt_q < LAST_BYTE;
        oready = state_q == S_START || (state_q == S_DATA && last_bit && more);
        odat_oe = state_q != S_IDLE;
        obusy = state_q != S_IDLE;
        odat = state_q == S_START ? START_BIT :
               state_q == S_DATA  ? shreg_q[7] :
               state_q == S_CRC   ? crc_bit : STOP_BIT;
        crc_rst = irst || state_q == S_IDLE || state_q == S_START;
        odone = done_q;
        oerr = err_q;
    end
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_cnt_d = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        crc_cnt_d = crc_cnt_q;
        done_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            S_IDLE: if (istart) state_d = S_START;
            S_START: begin
                if (ivalid) begin
                    shreg_d = idata;
                    bit_cnt_d = 3'd7;
                    byte_cnt_d = '0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_IDLE;
                    err_d = 1'b1;
                end
            end
            S_DATA: begin
                shreg_d = {shreg_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 3'd1;
                if (last_bit && more && ivalid) begin
                    shreg_d = idata;
                    bit_cnt_d = 3'd7;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end else if (last_bit && more) begin
                    state_d = S_IDLE;
                    err_d = 1'b1;
                end else if (last_bit) begin
                    state_d = S_CRC;
                    crc_cnt_d = CRC_CNT_W'(CRC_LEN - 1);
                end
            end
            S_CRC: begin
                crc_cnt_d = crc_cnt_q - 1'b1;
                if (crc_cnt_q == '0) state_d = S_STOP;
            end
            S_STOP: begin
                state_d = S_IDLE;
                done_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // datapath is parked at zero whenever the line goes idle
        if (state_d == S_IDLE) begin
            shreg_d = '0;
            bit_cnt_d = '0;
            byte_cnt_d = '0;
            crc_cnt_d = '0;
        end
    end
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bit_cnt_q <= '0;
            byte_cnt_q <= '0;
            crc_cnt_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_cnt_q <= crc_cnt_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end
    crc16 u_crc (
        .iclk   (iclk),
        .irst   (crc_rst),
        .idata  (shreg_q[7]),
        .iunload(state_q == S_CRC),
        .ocrc   (crc_bit)
    );
endmodule

// File: doc/sd_dat_tx_ctrl.md
Name: sd_dat_tx_ctrl

Overview:
- Sequences one SD write data block on DAT0 (1-bit bus mode): start bit, BLOCK_BYTES data bytes MSB-first, 16-bit CRC, end bit.
- Pulls bytes from the upstream buffer through a ready/valid handshake.
- Controls one crc16 instance: clears it before the block, feeds it the data bits, then switches it to unload so its CRC is shifted onto the line.
- Sits between the SD write data FIFO and the DAT0 pad driver; runs on the SD bit clock, one bit per cycle.

Parameters:
- BLOCK_BYTES, 512, number of data bytes per block (>= 1).
- CNT_W, 10, byte counter width; must satisfy 2^CNT_W >= BLOCK_BYTES.

Ports:
- iclk  in  1  SD bit clock; one DAT0 bit per rising edge.
- irst  in  1  synchronous, active-high reset.
- istart  in  1  start a block; sampled only in IDLE.
- idata  in  8  byte from the upstream buffer.
- ivalid  in  1  idata valid.
- oready  out  1  controller takes idata this cycle when ivalid=1.
- odat  out  1  DAT0 output value.
- odat_oe  out  1  DAT0 output enable.
- obusy  out  1  high in every state except IDLE.
- odone  out  1  one-cycle pulse: block fully sent.
- oerr  out  1  one-cycle pulse: underflow abort.

Behaviour:
- Clock and reset: single clock iclk; reset irst is synchronous, active-high.
- Reset values (also the values in IDLE): odat=1, odat_oe=0, oready=0, obusy=0, odone=0, oerr=0; state=IDLE; counters=0; crc16 held cleared.
- States: IDLE, START, DATA, CRC, STOP. Encode as a registered state vector. odat, odat_oe and oready are decoded from registered state only; they have no combinational path from istart.
- IDLE -> START on istart=1. istart is ignored in every other state.
- START (1 cycle): odat=0, odat_oe=1, oready=1.
  - If ivalid=1: load idata into an 8-bit shift register; bit_cnt=7; byte_cnt=0; go to DATA.
  - If ivalid=0: underflow abort (see below).
- DATA: odat=shreg[7], odat_oe=1. Shift left each cycle; bit_cnt decrements.
  - At bit_cnt==0, byte_cnt<BLOCK_BYTES-1: oready=1.
    - ivalid=1: reload shreg from idata, bit_cnt=7, byte_cnt+1.
    - ivalid=0: underflow abort.
  - At bit_cnt==0, byte_cnt==BLOCK_BYTES-1: go to CRC; crc_cnt=15.
- CRC (16 cycles): odat=crc16.ocrc, odat_oe=1, crc16.iunload=1. crc_cnt decrements; at 0 go to STOP.
- STOP (1 cycle): odat=1, odat_oe=1. Then go to IDLE with a registered odone=1 in the first IDLE cycle.
- crc16 control:
  - crc16.irst = irst OR (state is IDLE or START), so the CRC is zero at the first data bit.
  - crc16.idata = shreg[7] in DATA.
  - iunload=0 in DATA; iunload=1 in CRC.
  - In STOP and IDLE the crc16 contents are don't-care.
- Frame length: exactly 1 + 8*BLOCK_BYTES + 16 + 1 cycles with odat_oe=1. First odat_oe cycle is the cycle after istart is sampled.
- Underflow abort (oready=1 with ivalid=0):
  - Next cycle: IDLE, odat=1, odat_oe=0, oerr=1 for one cycle.
  - No odone for that block.
- irst mid-frame: next cycle is IDLE with reset values; no odone, no oerr.
- istart asserted in the same cycle as odone (IDLE): accepted; START follows. Back-to-back blocks are separated by exactly one IDLE cycle.

Decomposition:
- Shared package sd_dat_pkg:
  - state encoding;
  - START_BIT=0, STOP_BIT=1;
  - CRC_LEN=16;
  - default BLOCK_BYTES.
- One sub-module: crc16 (existing team block), instantiated once. All CRC arithmetic stays inside it; the controller only drives irst/idata/iunload and routes ocrc.

Test Plan:
- BLOCK_BYTES=1, byte 0x00 always valid, istart pulse -> odat: 0, eight 0s, sixteen 0s (CRC 0x0000), 1. odat_oe high for exactly 26 cycles; odone one cycle after STOP.
- BLOCK_BYTES=1, byte 0xFF -> odat: 0, eight 1s, CRC 0x1EF0 MSB-first, 1.
- BLOCK_BYTES=512, all bytes 0xFF, ivalid always 1 -> CRC field 0x7FA1. Exactly 512 oready&ivalid handshakes; frame length 4114 cycles.
- BLOCK_BYTES=4, ivalid dropped when the third byte is requested -> oerr pulse one cycle later; odat_oe=0 and odat=1 from that cycle; no odone; next istart produces a clean frame with correct CRC.
- irst asserted in the middle of the CRC phase -> IDLE next cycle with all reset values. The following block, bytes 0x00, BLOCK_BYTES=1, yields CRC 0x0000, proving the CRC was cleared.
- istart held high continuously, BLOCK_BYTES=1 -> consecutive frames separated by one IDLE cycle. istart during busy states has no effect; each frame carries an identical CRC.
